// File: rtl/hub75_scan_driver.sv
// HUB75 panel scan driver: reads the framebuffer two half-panel rows at a time,
// shifts one BCM bit plane per pass, latches it, then shows it for BASE_TICKS<<plane cycles.
module hub75_scan_driver #(
  parameter int COLS       = 32,
  parameter int ROWS       = 16,
  parameter int PWM_BITS   = 4,
  parameter int BASE_TICKS = 8,
  parameter int ADDR_WIDTH = $clog2(ROWS*COLS),
  parameter int DATA_WIDTH = 3*PWM_BITS,
  parameter int ROW_WIDTH  = (ROWS > 2) ? $clog2(ROWS/2) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  hub_r1,
  output logic                  hub_g1,
  output logic                  hub_b1,
  output logic                  hub_r2,
  output logic                  hub_g2,
  output logic                  hub_b2,
  output logic                  hub_clk,
  output logic                  hub_lat,
  output logic                  hub_oe_n,
  output logic [ROW_WIDTH-1:0]  hub_row,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PL_W   = (PWM_BITS > 1) ? $clog2(PWM_BITS) : 1;
  localparam int DISP_W = $clog2(BASE_TICKS << (PWM_BITS-1)) + 1;

  localparam logic [COL_W-1:0]     COL_LAST   = COL_W'(COLS-1);
  localparam logic [ROW_WIDTH-1:0] ROW_LAST   = ROW_WIDTH'(ROWS/2-1);
  localparam logic [PL_W-1:0]      PLANE_LAST = PL_W'(PWM_BITS-1);

  typedef enum logic [2:0] {
    IDLE, FETCH_TOP, FETCH_BOT, SETUP, CLK_HI, LATCH, DISPLAY
  } state_t;

  state_t                state, state_nxt;
  logic [ROW_WIDTH-1:0]  row, row_nxt;
  logic [PL_W-1:0]       plane, plane_nxt;
  logic [COL_W-1:0]      col, col_nxt;
  logic [DISP_W-1:0]     disp, disp_nxt, disp_load;
  logic                  stop_req, stopping;
  logic [DATA_WIDTH-1:0] top_word;

  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic                  clk_nxt, lat_nxt, oe_n_nxt, done_nxt;

  logic [PWM_BITS-1:0] top_r, top_g, top_b, bot_r, bot_g, bot_b;

  assign top_r = top_word[3*PWM_BITS-1 -: PWM_BITS];
  assign top_g = top_word[2*PWM_BITS-1 -: PWM_BITS];
  assign top_b = top_word[PWM_BITS-1   -: PWM_BITS];
  assign bot_r = ram_dout[3*PWM_BITS-1 -: PWM_BITS];
  assign bot_g = ram_dout[2*PWM_BITS-1 -: PWM_BITS];
  assign bot_b = ram_dout[PWM_BITS-1   -: PWM_BITS];

  assign disp_load = DISP_W'((BASE_TICKS << plane) - 1);
  // A stop request only takes effect once the current row-plane has been displayed.
  assign stopping  = stop_req | ~enable;
  assign busy      = (state != IDLE);

  function automatic logic [ADDR_WIDTH-1:0] pix_addr(input logic [ROW_WIDTH-1:0] r,
                                                     input logic [COL_W-1:0] c,
                                                     input logic bottom);
    int a;
    a = (int'(r) + (bottom ? ROWS/2 : 0)) * COLS + int'(c);
    return ADDR_WIDTH'(a);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      row      <= '0;
      plane    <= '0;
      col      <= '0;
      disp     <= '0;
      stop_req <= 1'b0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
      plane <= plane_nxt;
      col   <= col_nxt;
      disp  <= disp_nxt;
      if (state == IDLE)
        stop_req <= 1'b0;
      else if (!enable)
        stop_req <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    plane_nxt = plane;
    col_nxt   = col;
    disp_nxt  = disp;
    case (state)
      IDLE: begin
        row_nxt   = '0;
        plane_nxt = '0;
        col_nxt   = '0;
        disp_nxt  = '0;
        if (enable) state_nxt = FETCH_TOP;
      end
      FETCH_TOP: state_nxt = FETCH_BOT;
      FETCH_BOT: state_nxt = SETUP;
      SETUP:     state_nxt = CLK_HI;
      CLK_HI: begin
        if (col != COL_LAST) begin
          col_nxt   = col + 1'b1;
          state_nxt = FETCH_TOP;
        end else begin
          state_nxt = LATCH;
        end
      end
      LATCH: begin
        col_nxt   = '0;
        disp_nxt  = disp_load;
        state_nxt = DISPLAY;
      end
      DISPLAY: begin
        if (disp != '0) begin
          disp_nxt = disp - 1'b1;
        end else begin
          if (plane != PLANE_LAST) begin
            plane_nxt = plane + 1'b1;
          end else begin
            plane_nxt = '0;
            row_nxt   = (row != ROW_LAST) ? row + 1'b1 : '0;
          end
          state_nxt = FETCH_TOP;
          if (stopping) begin
            state_nxt = IDLE;
            row_nxt   = '0;
            plane_nxt = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Panel-side values are computed for the upcoming state so the outputs can be registered.
  always_comb begin
    addr_nxt = ram_addr;
    case (state_nxt)
      FETCH_TOP: addr_nxt = pix_addr(row_nxt, col_nxt, 1'b0);
      FETCH_BOT: addr_nxt = pix_addr(row_nxt, col_nxt, 1'b1);
      default:   addr_nxt = ram_addr;
    endcase
    clk_nxt  = (state_nxt == CLK_HI);
    lat_nxt  = (state_nxt == LATCH);
    oe_n_nxt = (state_nxt != DISPLAY);
    done_nxt = (state == DISPLAY) && (disp == '0) && (plane == PLANE_LAST) && (row == ROW_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr   <= '0;
      top_word   <= '0;
      hub_r1     <= 1'b0;
      hub_g1     <= 1'b0;
      hub_b1     <= 1'b0;
      hub_r2     <= 1'b0;
      hub_g2     <= 1'b0;
      hub_b2     <= 1'b0;
      hub_clk    <= 1'b0;
      hub_lat    <= 1'b0;
      hub_oe_n   <= 1'b1;
      hub_row    <= '0;
      frame_done <= 1'b0;
    end else begin
      ram_addr   <= addr_nxt;
      hub_clk    <= clk_nxt;
      hub_lat    <= lat_nxt;
      hub_oe_n   <= oe_n_nxt;
      frame_done <= done_nxt;
      if (state == FETCH_BOT)
        top_word <= ram_dout;
      // The bottom word arrives during SETUP and goes straight into the lower-half bits.
      if (state == SETUP) begin
        hub_r1 <= top_r[plane];
        hub_g1 <= top_g[plane];
        hub_b1 <= top_b[plane];
        hub_r2 <= bot_r[plane];
        hub_g2 <= bot_g[plane];
        hub_b2 <= bot_b[plane];
      end
      if (state == LATCH)
        hub_row <= row;
    end
  end

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Self-checking bench for hub75_scan_driver on a 4x4 panel with 4 BCM planes.
// A monitor logs shift-clock rises, OE-low runs and frame pulses; the main thread compares them.
module tb_hub75_scan_driver;

  localparam int COLS = 4, ROWS = 4, PWM_BITS = 4, BASE_TICKS = 8;
  localparam int AW = 4, DW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b0;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout = '0;
  logic          hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2;
  logic          hub_clk, hub_lat, hub_oe_n, frame_done, busy;
  logic [0:0]    hub_row;

  logic [DW-1:0] mem [16];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [5:0] rgb;
    logic [3:0] top;
    logic [3:0] bot;
  } rise_t;

  typedef struct {
    int         plane;
    int         col;
    logic [11:0] top;
    logic [11:0] bot;
    int         rgb;
  } vec_t;

  vec_t  vecs [16];
  rise_t rises[$];
  int    runs[$];
  int    lat_before[$];
  int    row_at_fall[$];
  int    fd_times[$];

  int         cycle = 0;
  int         low_cnt = 0;
  int         lat_long = 0;
  int         row_bad = 0;
  int         fd_long = 0;
  logic       prev_clk = 1'b0, prev_oe = 1'b1, prev_lat = 1'b0, prev_fd = 1'b0;
  logic [0:0] prev_row = '0;
  logic [3:0] ah1 = '0, ah2 = '0, ah3 = '0;

  hub75_scan_driver #(
    .COLS(COLS), .ROWS(ROWS), .PWM_BITS(PWM_BITS), .BASE_TICKS(BASE_TICKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .ram_addr(ram_addr), .ram_dout(ram_dout),
    .hub_r1(hub_r1), .hub_g1(hub_g1), .hub_b1(hub_b1),
    .hub_r2(hub_r2), .hub_g2(hub_g2), .hub_b2(hub_b2),
    .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe_n(hub_oe_n),
    .hub_row(hub_row), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_dout <= mem[ram_addr];

  always @(posedge clk) begin
    #1;
    cycle++;
    if (!rst_n) begin
      prev_clk = 1'b0;
      prev_oe  = 1'b1;
      prev_lat = 1'b0;
      prev_fd  = 1'b0;
      prev_row = hub_row;
      low_cnt  = 0;
    end else begin
      if (hub_clk && !prev_clk)
        rises.push_back('{rgb: {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2}, top: ah3, bot: ah2});
      if (!hub_oe_n) begin
        if (prev_oe) begin
          lat_before.push_back(int'(prev_lat));
          row_at_fall.push_back(int'(hub_row));
        end
        low_cnt++;
      end else if (!prev_oe) begin
        runs.push_back(low_cnt);
        low_cnt = 0;
      end
      if (hub_lat && prev_lat) lat_long++;
      if ((hub_row != prev_row) && !prev_oe) row_bad++;
      if (frame_done) begin
        fd_times.push_back(cycle);
        if (prev_fd) fd_long++;
      end
      prev_clk = hub_clk;
      prev_oe  = hub_oe_n;
      prev_lat = hub_lat;
      prev_fd  = frame_done;
      prev_row = hub_row;
      ah3 = ah2;
      ah2 = ah1;
      ah1 = ram_addr;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input int n);
    enable = en;
    repeat (n) @(negedge clk);
  endtask

  task automatic clearLogs();
    rises.delete();
    runs.delete();
    lat_before.delete();
    row_at_fall.delete();
    fd_times.delete();
    lat_long = 0;
    row_bad  = 0;
    fd_long  = 0;
  endtask

  function automatic logic [31:0] packOut();
    return 32'({ram_addr, hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2,
                hub_clk, hub_lat, hub_row, frame_done, busy, hub_oe_n});
  endfunction

  initial begin
    int exp_runs [8];
    exp_runs = '{8, 16, 32, 64, 8, 16, 32, 64};

    // {plane, col, top word at row0/col, bottom word at row2/col, expected {r1,g1,b1,r2,g2,b2}}
    vecs[0]  = '{0, 0, 12'hF00, 12'h000, 6'b100000};
    vecs[1]  = '{0, 1, 12'h842, 12'h000, 6'b000000};
    vecs[2]  = '{0, 2, 12'h000, 12'h124, 6'b000100};
    vecs[3]  = '{0, 3, 12'h000, 12'h00F, 6'b000001};
    vecs[4]  = '{1, 0, 12'hF00, 12'h000, 6'b100000};
    vecs[5]  = '{1, 1, 12'h842, 12'h000, 6'b001000};
    vecs[6]  = '{1, 2, 12'h000, 12'h124, 6'b000010};
    vecs[7]  = '{1, 3, 12'h000, 12'h00F, 6'b000001};
    vecs[8]  = '{2, 0, 12'hF00, 12'h000, 6'b100000};
    vecs[9]  = '{2, 1, 12'h842, 12'h000, 6'b010000};
    vecs[10] = '{2, 2, 12'h000, 12'h124, 6'b000001};
    vecs[11] = '{2, 3, 12'h000, 12'h00F, 6'b000001};
    vecs[12] = '{3, 0, 12'hF00, 12'h000, 6'b100000};
    vecs[13] = '{3, 1, 12'h842, 12'h000, 6'b100000};
    vecs[14] = '{3, 2, 12'h000, 12'h124, 6'b000000};
    vecs[15] = '{3, 3, 12'h000, 12'h00F, 6'b000001};

    for (int i = 0; i < 16; i++) mem[i] = '0;
    for (int i = 0; i < 16; i++) begin
      mem[vecs[i].col]     = vecs[i].top;
      mem[8 + vecs[i].col] = vecs[i].bot;
    end

    // Reset and idle
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", packOut(), 32'h1);
    rst_n = 1'b1;
    applyStimulus(1'b0, 50);
    checkOutput("idle_outputs", packOut(), 32'h1);
    checkOutput("idle_no_activity", rises.size() + runs.size() + fd_times.size(), 0);

    // Continuous scanning over three frames
    applyStimulus(1'b1, 1);
    for (int k = 0; k < 2000 && fd_times.size() < 3; k++) @(negedge clk);
    checkOutput("wait_three_frames", fd_times.size() >= 3, 1);

    checkOutput("rise_count", rises.size() >= 32, 1);
    if (rises.size() >= 32) begin
      for (int i = 0; i < 16; i++) begin
        checkOutput($sformatf("rgb_p%0d_c%0d", vecs[i].plane, vecs[i].col), rises[i].rgb, vecs[i].rgb);
        checkOutput($sformatf("addr_top_r0_p%0d_c%0d", vecs[i].plane, vecs[i].col), rises[i].top, vecs[i].col);
        checkOutput($sformatf("addr_bot_r0_p%0d_c%0d", vecs[i].plane, vecs[i].col), rises[i].bot, 8 + vecs[i].col);
      end
      for (int i = 16; i < 32; i++) begin
        checkOutput($sformatf("rgb_r1_%0d", i), rises[i].rgb, 0);
        checkOutput($sformatf("addr_top_r1_%0d", i), rises[i].top, 4 + (i % 4));
        checkOutput($sformatf("addr_bot_r1_%0d", i), rises[i].bot, 12 + (i % 4));
      end
    end

    checkOutput("run_count", runs.size() >= 8, 1);
    if (runs.size() >= 8)
      for (int i = 0; i < 8; i++) checkOutput($sformatf("oe_run_%0d", i), runs[i], exp_runs[i]);

    checkOutput("fall_count", row_at_fall.size() >= 16, 1);
    if (row_at_fall.size() >= 16)
      for (int i = 0; i < 16; i++) checkOutput($sformatf("hub_row_%0d", i), row_at_fall[i], (i / 4) % 2);
    for (int i = 0; i < lat_before.size(); i++)
      checkOutput($sformatf("lat_before_run_%0d", i), lat_before[i], 1);

    if (fd_times.size() >= 3) begin
      checkOutput("frame_period_1", fd_times[1] - fd_times[0], 376);
      checkOutput("frame_period_2", fd_times[2] - fd_times[1], 376);
    end
    checkOutput("lat_pulse_width", lat_long, 0);
    checkOutput("row_change_while_lit", row_bad, 0);
    checkOutput("frame_done_width", fd_long, 0);

    // Stop request during plane 2 shifting
    rst_n = 1'b0;
    clearLogs();
    applyStimulus(1'b0, 2);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1);
    for (int k = 0; k < 400 && runs.size() < 2; k++) @(negedge clk);
    checkOutput("wait_plane1_done", runs.size(), 2);
    applyStimulus(1'b1, 5);
    applyStimulus(1'b0, 1);
    for (int k = 0; k < 200 && busy; k++) @(negedge clk);
    checkOutput("stop_busy", busy, 0);
    checkOutput("stop_run_count", runs.size(), 3);
    if (runs.size() >= 3) checkOutput("stop_plane2_run", runs[2], 32);
    checkOutput("stop_rises", rises.size(), 12);
    checkOutput("stop_no_frame_done", fd_times.size(), 0);
    applyStimulus(1'b0, 10);
    checkOutput("stopped_oe", hub_oe_n, 1);
    checkOutput("stopped_busy", busy, 0);
    checkOutput("stopped_no_runs", runs.size(), 3);

    // Restart begins again at row 0, plane 0
    applyStimulus(1'b1, 1);
    for (int k = 0; k < 200 && runs.size() < 4; k++) @(negedge clk);
    checkOutput("restart_run_count", runs.size(), 4);
    if (runs.size() >= 4) checkOutput("restart_plane0_run", runs[3], 8);
    if (row_at_fall.size() >= 4) checkOutput("restart_row", row_at_fall[3], 0);
    if (rises.size() >= 13) checkOutput("restart_addr", rises[12].top, 0);

    // Asynchronous reset while the panel is lit
    for (int k = 0; k < 400 && hub_oe_n; k++) @(negedge clk);
    checkOutput("wait_display", hub_oe_n, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_oe", hub_oe_n, 1);
    checkOutput("async_reset_busy", busy, 0);
    enable = 1'b0;
    @(negedge clk);
    checkOutput("async_reset_outputs", packOut(), 32'h1);
    rst_n = 1'b1;
    applyStimulus(1'b0, 20);
    checkOutput("post_reset_idle", packOut(), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
